// File: rtl/tag_array_nway.sv
// N-way set-associative tag store with per-set replacement state and a dirty-line flush engine.
// Optional feature: define TAG_ARRAY_PLRU_EN to swap the FIFO pointer for a per-set tree pseudo-LRU.
module tag_array_nway #(
  parameter int ATEG_WIDTH   = 7,
  parameter int AINDEX_WIDTH = 6,
  parameter int WAYS         = 8,
  parameter int ACH_WIDTH    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ATEG_WIDTH+AINDEX_WIDTH-1:0] req_addr,
  input  logic                               req_fill,
  input  logic                               req_md,
  output logic                               resp_valid,
  output logic                               resp_hit,
  output logic [ACH_WIDTH-1:0]               resp_way,
  output logic                               resp_victim_valid,
  output logic                               resp_victim_dirty,
  output logic [ATEG_WIDTH-1:0]              resp_victim_tag,
  input  logic                               flush_req,
  output logic                               flush_done,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0] wb_addr,
  output logic [ACH_WIDTH-1:0]               wb_way
);
  localparam int SETS  = 2**AINDEX_WIDTH;
  localparam int CNT_W = AINDEX_WIDTH + ACH_WIDTH;
`ifdef TAG_ARRAY_PLRU_EN
  localparam int RW = WAYS - 1;
`else
  localparam int RW = ACH_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  state_t                state;
  logic [ATEG_WIDTH-1:0] tag_q  [SETS][WAYS];
  logic [WAYS-1:0]       val_q  [SETS];
  logic [WAYS-1:0]       mod_q  [SETS];
  logic [RW-1:0]         repl_q [SETS];
  logic [CNT_W-1:0]      cnt;

  logic [AINDEX_WIDTH-1:0] req_set, scan_set;
  logic [ATEG_WIDTH-1:0]   req_tag;
  logic [ACH_WIDTH-1:0]    scan_way, hit_way, inv_way, victim, repl_pick;
  logic [WAYS-1:0]         hit_vec;
  logic                    hit, inv_any, accept, scan_last;
  logic [RW-1:0]           repl_nxt;

`ifdef TAG_ARRAY_PLRU_EN
  // Tree bit 0 steers left; the heap walk from the root lands on a leaf = way.
  function automatic logic [ACH_WIDTH-1:0] plru_pick(input logic [WAYS-2:0] t);
    int node;
    node = 0;
    for (int l = 0; l < ACH_WIDTH; l++) node = 2*node + 1 + int'(t[node]);
    return ACH_WIDTH'(node - (WAYS-1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [ACH_WIDTH-1:0] w);
    logic [WAYS-2:0] r;
    int node;
    r = t;
    node = 0;
    for (int l = 0; l < ACH_WIDTH; l++) begin
      r[node] = ~w[ACH_WIDTH-1-l];
      node = 2*node + 1 + int'(w[ACH_WIDTH-1-l]);
    end
    return r;
  endfunction
`endif

  assign req_tag   = req_addr[ATEG_WIDTH+AINDEX_WIDTH-1:AINDEX_WIDTH];
  assign req_set   = req_addr[AINDEX_WIDTH-1:0];
  assign req_ready = (state == IDLE) && !flush_req;
  assign accept    = req_valid && req_ready;
  assign scan_set  = cnt[CNT_W-1:ACH_WIDTH];
  assign scan_way  = cnt[ACH_WIDTH-1:0];
  assign scan_last = (cnt == {CNT_W{1'b1}});

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = val_q[req_set][w] && (tag_q[req_set][w] == req_tag);
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = ACH_WIDTH'(w);
      if (!val_q[req_set][w]) inv_way = ACH_WIDTH'(w);
    end
    hit     = |hit_vec;
    inv_any = ~&val_q[req_set];
`ifdef TAG_ARRAY_PLRU_EN
    repl_pick = plru_pick(repl_q[req_set]);
`else
    repl_pick = repl_q[req_set];
`endif
    victim   = inv_any ? inv_way : repl_pick;
    repl_nxt = repl_q[req_set];
`ifdef TAG_ARRAY_PLRU_EN
    if (hit) repl_nxt = plru_touch(repl_q[req_set], hit_way);
    else if (req_fill) repl_nxt = plru_touch(repl_q[req_set], victim);
`else
    if (!hit && req_fill && !inv_any) repl_nxt = repl_q[req_set] + RW'(1);
`endif
  end

  // Tag contents need no reset; validity lives in val_q.
  always_ff @(posedge clk)
    if (accept && !hit && req_fill) tag_q[req_set][victim] <= req_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_way          <= '0;
      resp_victim_valid <= 1'b0;
      resp_victim_dirty <= 1'b0;
      resp_victim_tag   <= '0;
      flush_done        <= 1'b0;
      wb_valid          <= 1'b0;
      wb_addr           <= '0;
      wb_way            <= '0;
      for (int s = 0; s < SETS; s++) begin
        val_q[s]  <= '0;
        mod_q[s]  <= '0;
        repl_q[s] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (accept) begin
            resp_valid        <= 1'b1;
            resp_hit          <= hit;
            resp_way          <= '0;
            resp_victim_valid <= 1'b0;
            resp_victim_dirty <= 1'b0;
            resp_victim_tag   <= '0;
            repl_q[req_set]   <= repl_nxt;
            if (hit) begin
              resp_way <= hit_way;
              if (req_md) mod_q[req_set][hit_way] <= 1'b1;
            end else if (req_fill) begin
              resp_way                <= victim;
              resp_victim_valid       <= val_q[req_set][victim];
              resp_victim_dirty       <= val_q[req_set][victim] & mod_q[req_set][victim];
              resp_victim_tag         <= val_q[req_set][victim] ? tag_q[req_set][victim] : '0;
              val_q[req_set][victim]  <= 1'b1;
              mod_q[req_set][victim]  <= req_md;
            end
          end
        end
        SCAN: begin
          if (val_q[scan_set][scan_way] && mod_q[scan_set][scan_way]) begin
            state    <= WB;
            wb_valid <= 1'b1;
            wb_addr  <= {tag_q[scan_set][scan_way], scan_set};
            wb_way   <= scan_way;
          end else begin
            val_q[scan_set][scan_way] <= 1'b0;
            mod_q[scan_set][scan_way] <= 1'b0;
            cnt <= cnt + CNT_W'(1);
            if (scan_last) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            val_q[scan_set][scan_way] <= 1'b0;
            mod_q[scan_set][scan_way] <= 1'b0;
            cnt <= cnt + CNT_W'(1);
            if (scan_last) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          for (int s = 0; s < SETS; s++) repl_q[s] <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_array_nway.sv
// Directed bench for tag_array_nway (4 ways, 4 sets, 7-bit tags) in its default FIFO build.
module tb_tag_array_nway;
  localparam int TW = 7, IW = 2, WY = 4, CW = 2, AW = TW + IW;

  logic          clk, reset;
  logic          req_valid, req_ready, req_fill, req_md;
  logic [AW-1:0] req_addr;
  logic          resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty;
  logic [CW-1:0] resp_way;
  logic [TW-1:0] resp_victim_tag;
  logic          flush_req, flush_done, wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [CW-1:0] wb_way;

  tag_array_nway #(.ATEG_WIDTH(TW), .AINDEX_WIDTH(IW), .WAYS(WY), .ACH_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_fill(req_fill), .req_md(req_md),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_victim_valid(resp_victim_valid), .resp_victim_dirty(resp_victim_dirty),
    .resp_victim_tag(resp_victim_tag),
    .flush_req(flush_req), .flush_done(flush_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fill;
    logic          md;
    logic [TW-1:0] tag;
    logic [IW-1:0] set;
    logic          hit;
    logic [CW-1:0] way;
    logic          vv;
    logic          vd;
    logic [TW-1:0] vt;
  } vec_t;

  vec_t vecs [19];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one request right after an edge; consecutive calls are back-to-back.
  task automatic run_req(input vec_t v, input string nm);
    req_fill  = v.fill;
    req_md    = v.md;
    req_addr  = {v.tag, v.set};
    req_valid = 1'b1;
    #1 chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_fill  = 1'b0;
    req_md    = 1'b0;
    chk({nm, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({nm, "_hit"},    32'(resp_hit), 32'(v.hit));
    chk({nm, "_way"},    32'(resp_way), 32'(v.way));
    chk({nm, "_vvalid"}, 32'(resp_victim_valid), 32'(v.vv));
    chk({nm, "_vdirty"}, 32'(resp_victim_dirty), 32'(v.vd));
    chk({nm, "_vtag"},   32'(resp_victim_tag), 32'(v.vt));
  endtask

  initial begin
    int n, stall, hs, done_n, waited;
    logic [AW-1:0] exp_addr [2];
    logic [CW-1:0] exp_way  [2];

    //            fill md  tag    set  hit way vv vd vt
    vecs[0]  = '{1'b0, 1'b0, 7'h15, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[1]  = '{1'b1, 1'b0, 7'h10, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[2]  = '{1'b1, 1'b0, 7'h11, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0, 7'h00};
    vecs[3]  = '{1'b1, 1'b0, 7'h12, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0, 7'h00};
    vecs[4]  = '{1'b1, 1'b0, 7'h13, 2'd2, 1'b0, 2'd3, 1'b0, 1'b0, 7'h00};
    vecs[5]  = '{1'b1, 1'b0, 7'h14, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 7'h10};
    vecs[6]  = '{1'b1, 1'b0, 7'h15, 2'd2, 1'b0, 2'd1, 1'b1, 1'b0, 7'h11};
    vecs[7]  = '{1'b0, 1'b1, 7'h12, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 7'h00};
    vecs[8]  = '{1'b0, 1'b0, 7'h14, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[9]  = '{1'b1, 1'b0, 7'h16, 2'd2, 1'b0, 2'd2, 1'b1, 1'b1, 7'h12};
    vecs[10] = '{1'b0, 1'b0, 7'h12, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[11] = '{1'b1, 1'b0, 7'h13, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0, 7'h00};
    vecs[12] = '{1'b0, 1'b0, 7'h16, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 7'h00};
    vecs[13] = '{1'b1, 1'b0, 7'h20, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[14] = '{1'b1, 1'b0, 7'h21, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 7'h00};
    vecs[15] = '{1'b1, 1'b0, 7'h22, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 7'h00};
    vecs[16] = '{1'b1, 1'b1, 7'h23, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0, 7'h00};
    vecs[17] = '{1'b1, 1'b0, 7'h30, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00};
    vecs[18] = '{1'b1, 1'b1, 7'h31, 2'd3, 1'b0, 2'd1, 1'b0, 1'b0, 7'h00};
    exp_addr[0] = {7'h23, 2'd0};  exp_way[0] = 2'd3;
    exp_addr[1] = {7'h31, 2'd3};  exp_way[1] = 2'd1;

    reset = 1'b1; req_valid = 1'b0; req_fill = 1'b0; req_md = 1'b0; req_addr = '0;
    flush_req = 1'b0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_wbvalid", 32'(wb_valid), 32'd0);
    chk("rst_done", 32'(flush_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 19; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Flush and request together: flush must win.
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_addr  = {7'h23, 2'd0};
    #1 chk("clash_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    req_valid = 1'b0;
    chk("clash_not_accepted", 32'(resp_valid), 32'd0);
    n = 1; stall = 0; hs = 0; done_n = 0;
    while (n < 100 && done_n == 0) begin
      if (wb_valid) begin
        if (hs < 2) begin
          chk($sformatf("wb%0d_addr", hs), 32'(wb_addr), 32'(exp_addr[hs]));
          chk($sformatf("wb%0d_way", hs), 32'(wb_way), 32'(exp_way[hs]));
        end
        if (stall < 3) begin
          wb_ready = 1'b0;
          stall++;
        end else begin
          wb_ready = 1'b1;
          hs++;
        end
      end else begin
        wb_ready = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (flush_done) done_n = n;
    end
    wb_ready = 1'b0;
    chk("flush_cycles", 32'(done_n), 32'd22);
    chk("wb_handshakes", 32'(hs), 32'd2);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(flush_done), 32'd0);
    chk("post_flush_ready", 32'(req_ready), 32'd1);
    run_req('{1'b0, 1'b0, 7'h23, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "post_flush_s0");
    run_req('{1'b0, 1'b0, 7'h16, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "post_flush_s2");
    run_req('{1'b1, 1'b0, 7'h50, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "post_flush_fill");

    // Reset while a writeback is pending.
    run_req('{1'b1, 1'b1, 7'h40, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "pre_abort_fill");
    flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    waited = 0;
    while (!wb_valid && waited < 40) begin
      @(posedge clk);
      #1 waited++;
    end
    chk("abort_wb_seen", 32'(wb_valid), 32'd1);
    chk("abort_wb_addr", 32'(wb_addr), 32'({7'h40, 2'd1}));
    #2 reset = 1'b1;
    #1 chk("abort_wb_drop", 32'(wb_valid), 32'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle_ready", 32'(req_ready), 32'd1);
    chk("abort_no_done", 32'(flush_done), 32'd0);
    run_req('{1'b0, 1'b0, 7'h40, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "abort_lookup");
    run_req('{1'b1, 1'b0, 7'h41, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00}, "abort_fill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tag_array_nway.md
Name: tag_array_nway

Overview:
- Parametrised N-way set-associative tag store with per-set replacement state, one-cycle registered lookup/fill response, and a flush engine that streams dirty victims out over a valid/ready port.
- Replaces per-way tag channels and the external FIFO way pointer.
- Sits between the cache controller (request side) and the writeback path (wb side).

Parameters:
- ATEG_WIDTH, 7, tag bits of the address.
- AINDEX_WIDTH, 6, set index bits; SETS = 2**AINDEX_WIDTH.
- WAYS, 8, associativity; power of 2, >= 2.
- ACH_WIDTH, 3, way index width; must equal log2(WAYS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_addr  in  ATEG_WIDTH+AINDEX_WIDTH  {tag, index}.
- req_fill  in  1  0 = lookup, 1 = lookup-and-allocate on miss.
- req_md  in  1  mark the hit or filled line dirty.
- resp_valid  out  1  one-cycle pulse, one cycle after acceptance.
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  ACH_WIDTH  hit way, or allocated way on a fill miss.
- resp_victim_valid  out  1  allocated way held a valid line.
- resp_victim_dirty  out  1  that line was dirty.
- resp_victim_tag  out  ATEG_WIDTH  that line's tag.
- flush_req  in  1  start flush, sampled in IDLE.
- flush_done  out  1  one-cycle pulse at the end of the flush.
- wb_valid  out  1  dirty line presented during flush.
- wb_ready  in  1  writeback sink accepts.
- wb_addr  out  ATEG_WIDTH+AINDEX_WIDTH  {tag, index} of the dirty line.
- wb_way  out  ACH_WIDTH  way of the dirty line.

Behaviour:
- Storage: per (set, way) {tag, val, mod}; per set a replacement pointer of ACH_WIDTH bits.
- Reset (async): all val=0, mod=0, pointers=0, FSM=IDLE, all outputs 0. Tag contents are don't-care.
- States: IDLE, SCAN, WB, DONE.
- req_ready = (state==IDLE) && !flush_req. flush_req wins over a simultaneous request.
- Accepted request (edge E): lookup is combinational against the set; the array update is written at E; response registers load at E; resp_valid is high for the cycle after E.
  - A back-to-back request to the same set sees the update.
- Hit: resp_hit=1, resp_way=matching way, victim fields=0. If req_md, mod=1. Replacement state unchanged (FIFO). A fill that hits is treated as a lookup.
- Multiple matching ways: illegal; lowest way is reported.
- Lookup miss: resp_hit=0, resp_way=0, no state change.
- Fill miss:
  - Victim = lowest-index invalid way; if none, victim = set pointer, and the pointer increments mod WAYS.
  - Victim fields = old {val, mod, tag}.
  - Victim entry written {req tag, val=1, mod=req_md}; resp_way = victim.
- Flush:
  - IDLE with flush_req goes to SCAN; counter {set, way} starts at 0.
  - SCAN, one entry per cycle: if val&mod, go to WB; else clear val/mod and advance.
  - WB: wb_valid=1 with stable wb_addr/wb_way until wb_ready. On handshake, clear the entry, advance, return to SCAN.
  - After the last entry (set SETS-1, way WAYS-1), go to DONE: all pointers = 0, flush_done=1 for one cycle, then IDLE.
  - Total cycles = SETS*WAYS + (dirty lines + wb stall cycles) + 1.
- wb_ready outside WB: ignored. flush_req outside IDLE: ignored.
- Reset mid-flush: immediate abort to IDLE; wb_valid drops asynchronously; the array is fully invalidated.

Optional Feature:
- Macro TAG_ARRAY_PLRU_EN.
- Defined: per-set tree pseudo-LRU of WAYS-1 bits replaces the FIFO pointer.
  - Hits and fill allocations both update the tree to point away from the accessed way.
  - Victim with no invalid way = tree-selected way.
  - Reset and flush DONE clear the tree to 0, which selects way 0.
- Undefined: FIFO pointer exactly as in Behaviour; no PLRU logic.

Test Plan (bench: WAYS=4, AINDEX_WIDTH=2, ATEG_WIDTH=7):
- Reset, then lookup addr {tag 0x15, set 1} -> next cycle resp_valid=1, resp_hit=0, resp_way=0.
- Fills with tags 0x10,0x11,0x12,0x13 to set 2 -> resp_way 0,1,2,3, victim_valid=0. Then fill tag 0x14 -> resp_way=0, victim_valid=1, victim_tag=0x10. Then fill tag 0x15 -> way 1, victim_tag=0x11 (FIFO).
- Lookup tag 0x12 set 2 with req_md=1 -> resp_hit=1, resp_way=2. A later fill victimising way 2 reports victim_dirty=1.
- Dirty lines at (set 0, way 3) and (set 3, way 1); flush with wb_ready low 3 cycles on the first -> exactly two wb handshakes with wb_addr {tag, 0} then {tag, 3}. flush_done arrives 16+2+3+1 cycles after flush_req; a subsequent lookup misses.
- flush_req and req_valid asserted together in IDLE -> req_ready=0, request not accepted, flush starts.
- Assert reset during WB -> wb_valid=0 immediately; after release, state IDLE and lookup of the prior tag misses.
